// File: rtl/ethernet_frame_fcs_inserter_if.sv
// Byte-stream handshake bundle used on both sides of the FCS inserter.
// The source drives data/valid/last; the sink drives ready.
interface ethernet_frame_fcs_inserter_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/ethernet_frame_fcs_inserter.sv
// Forwards an Ethernet frame, zero-pads it to MIN_FRAME_BYTES and appends the
// reflected CRC-32 FCS (LSB first) through a single output register.
module ethernet_frame_fcs_inserter #(
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic                          clock,
  input  logic                          reset,
  ethernet_frame_fcs_inserter_if.slave  s,
  ethernet_frame_fcs_inserter_if.master m,
  output logic                          frame_done,
  output logic                          frame_padded
);

  localparam logic [10:0] MinBytes = 11'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {StData, StPad, StFcs} state_e;

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        hold_last_q, hold_last_d;
  logic [10:0] count_q, count_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  idx_q, idx_d;
  logic        padded_q, padded_d;

  logic        out_hs;
  logic        out_free;
  logic        s_ready;
  logic [10:0] count_inc;
  logic [31:0] crc_upd;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    hold_last_d = hold_last_q;
    count_d     = count_q;
    crc_d       = crc_q;
    idx_d       = idx_q;
    padded_d    = padded_q;

    out_hs    = valid_q & m.ready;
    out_free  = ~valid_q | m.ready;
    count_inc = (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
    crc_upd   = crc_step(crc_q, data_q);
    fcs_word  = ~crc_q;
    s_ready   = (state_q == StData) && out_free && !(valid_q && hold_last_q);

    // Register drains on handoff unless reloaded below.
    if (out_hs) begin
      valid_d = 1'b0;
    end
    if (out_hs && (state_q != StFcs)) begin
      count_d = count_inc;
      crc_d   = crc_upd;
    end

    unique case (state_q)
      StData: begin
        if (s_ready && s.valid) begin
          data_d      = s.data;
          valid_d     = 1'b1;
          hold_last_d = s.last;
        end else if (out_hs && hold_last_q) begin
          hold_last_d = 1'b0;
          valid_d     = 1'b1;
          if (count_inc < MinBytes) begin
            state_d  = StPad;
            data_d   = 8'h00;
            padded_d = 1'b1;
          end else begin
            // FCS byte 0 must include the byte being handed off right now.
            state_d = StFcs;
            data_d  = ~crc_upd[7:0];
            idx_d   = 2'd0;
          end
        end
      end
      StPad: begin
        if (out_hs) begin
          valid_d = 1'b1;
          if (count_inc < MinBytes) begin
            data_d = 8'h00;
          end else begin
            state_d = StFcs;
            data_d  = ~crc_upd[7:0];
            idx_d   = 2'd0;
          end
        end
      end
      StFcs: begin
        if (out_hs) begin
          if (idx_q == 2'd3) begin
            state_d  = StData;
            last_d   = 1'b0;
            count_d  = '0;
            crc_d    = '1;
            padded_d = 1'b0;
          end else begin
            idx_d   = idx_q + 2'd1;
            data_d  = fcs_word[{idx_d, 3'b000} +: 8];
            valid_d = 1'b1;
            last_d  = (idx_q == 2'd2);
          end
        end
      end
      default: begin
        state_d = StData;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StData;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      hold_last_q <= 1'b0;
      count_q     <= '0;
      crc_q       <= '1;
      idx_q       <= 2'd0;
      padded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      hold_last_q <= hold_last_d;
      count_q     <= count_d;
      crc_q       <= crc_d;
      idx_q       <= idx_d;
      padded_q    <= padded_d;
    end
  end

  assign s.ready      = s_ready;
  assign m.data       = data_q;
  assign m.valid      = valid_q;
  assign m.last       = last_q;
  assign frame_done   = out_hs & last_q;
  assign frame_padded = padded_q;

endmodule
